uart_rx: RTL and testbench

//   8N1 UART receiver: the receive-side counterpart of the serial transmitter on
//   the same link. Samples the asynchronous serial input at 16x the baud rate,

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_tick.sv | 39 +++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART receiver.
//   - rx_state_e   : receiver FSM state encoding
//   - OVERSAMPLE   : oversample ticks per bit
//   - MID_SAMPLE   : tick index of the start-bit centre
//   - DATA_BITS    : payload bits per frame
//   - DEF_OVS_DIV  : sysclk cycles per oversample tick (50 MHz / (9600*16))
//   - DEF_DIV_W    : width of the tick divider counter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 8;
  localparam int DATA_BITS   = 8;
  localparam int DEF_OVS_DIV = 326;
  localparam int DEF_DIV_W   = 9;

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick generator.
//   Counts sysclk cycles 0..OVS_DIV-1 and flags the last count as a tick.
//   A synchronous clear holds the counter at zero so the tick phase can be
//   locked to an external event.
// Ports:
//   sysclk in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  synchronous clear; counter held at 0 while high
//   tick   out 1  high for one sysclk when the counter is at OVS_DIV-1
module uart_rx_tick #(
  parameter int OVS_DIV = 326,
  parameter int DIV_W   = 9
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(OVS_DIV - 1);

  logic [DIV_W-1:0] cnt_r;

  // Divider counter: clears on request, otherwise wraps at OVS_DIV-1.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling.
//   The serial input is double-registered, a start edge is qualified at the
//   centre of the start bit, eight data bits are captured LSB first at bit
//   centres and the stop bit is checked. Good bytes are handed to the host
//   through a valid/ack handshake one cycle after the stop-bit sample.
// Ports:
//   sysclk    in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   rx        in  1  raw serial line, idle high, asynchronous to sysclk
//   ack       in  1  host consumed dout; clears valid and overrun
//   dout      out 8  last good received byte, stable while valid=1
//   valid     out 1  byte available, held until ack
//   frame_err out 1  one-cycle pulse when the stop bit is sampled low
//   overrun   out 1  sticky: a byte completed while valid=1 without ack
//   busy      out 1  receiver FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV = DEF_OVS_DIV,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [3:0] T_MID    = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] T_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic       rx_meta_r;
  logic       rx_sync_r;
  rx_state_e  state_r;
  rx_state_e  state_nx_s;
  logic [3:0] t_r;
  logic [3:0] t_nx_s;
  logic [2:0] bit_r;
  logic [2:0] bit_nx_s;
  logic [7:0] shreg_r;
  logic [7:0] shreg_nx_s;
  logic       dlv_r;
  logic       dlv_nx_s;
  logic       fe_nx_s;
  logic       tick_s;
  logic       tick_clr_s;
  logic [7:0] dout_r;
  logic       valid_r;
  logic       frame_err_r;
  logic       overrun_r;
  logic       busy_r;

  // Divider and tick count sit at zero while idle, so the first tick after a
  // start edge always lands a fixed number of cycles later.
  assign tick_clr_s = (state_r == ST_IDLE);

  uart_rx_tick #(
    .OVS_DIV (OVS_DIV),
    .DIV_W   (DIV_W)
  ) u_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .clr    (tick_clr_s),
    .tick   (tick_s)
  );

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, tick counter, bit index and shift register logic.
  always_comb begin
    state_nx_s = state_r;
    bit_nx_s   = bit_r;
    shreg_nx_s = shreg_r;
    dlv_nx_s   = 1'b0;
    fe_nx_s    = 1'b0;
    if (tick_s) begin
      t_nx_s = t_r + 4'd1;
    end else begin
      t_nx_s = t_r;
    end

    case (state_r)
      ST_IDLE: begin
        t_nx_s   = 4'd0;
        bit_nx_s = 3'd0;
        if (!rx_sync_r) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (t_r == T_MID)) begin
          if (!rx_sync_r) begin
            // Start bit still low at its centre: restart the tick count
            // so later samples fall on bit centres.
            state_nx_s = ST_DATA;
            t_nx_s     = 4'd0;
            bit_nx_s   = 3'd0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (t_r == T_LAST)) begin
          shreg_nx_s = {rx_sync_r, shreg_r[7:1]};
          if (bit_r == BIT_LAST) begin
            state_nx_s = ST_STOP;
          end else begin
            bit_nx_s = bit_r + 3'd1;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s && (t_r == T_LAST)) begin
          if (rx_sync_r) begin
            dlv_nx_s   = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            fe_nx_s    = 1'b1;
            state_nx_s = ST_BRK;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_BRK: begin
        // A held-low line must return high before a new start is accepted.
        if (rx_sync_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BRK;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        t_nx_s     = 4'd0;
        bit_nx_s   = 3'd0;
      end
    endcase
  end

  // FSM state, counters, shifter and delivery strobe registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      t_r         <= 4'd0;
      bit_r       <= 3'd0;
      shreg_r     <= 8'd0;
      dlv_r       <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      t_r         <= t_nx_s;
      bit_r       <= bit_nx_s;
      shreg_r     <= shreg_nx_s;
      dlv_r       <= dlv_nx_s;
      frame_err_r <= fe_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  // Host handshake: deliver, drop with overrun, or clear on ack.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r    <= 8'd0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (dlv_r) begin
      if (!valid_r || ack) begin
        dout_r  <= shreg_r;
        valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (ack) begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r   <= valid_r;
      overrun_r <= overrun_r;
    end
  end

  assign dout      = dout_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (OVS_DIV=4, 64 clk/bit).
// A bit-time model of the receiver predicts every output each cycle; literal
// expectations after each scenario pin the model.
module tb_uart_rx;

  localparam int OVS_DIV = 4;
  localparam int DIV_W   = 2;
  localparam int BIT     = 16 * OVS_DIV;
  localparam int HALF    = BIT / 2;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic       ack    = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int lat    = 0;
  int fe0    = 0;
  int p1     = 0;

  uart_rx #(.OVS_DIV(OVS_DIV), .DIV_W(DIV_W)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .ack       (ack),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  initial forever begin
    @(posedge sysclk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (bit-time arithmetic) ----------------
  // The receiver sees rx two clocks late; a frame is timed from the clock on
  // which the delayed line is first seen low. Bit k (0=start, 1..8 data,
  // 9=stop) is judged HALF + k*BIT clocks after that point.
  logic       m_d1 = 1'b1;
  logic       m_d2 = 1'b1;
  logic       m_rxs;
  int         m_mode = 0;   // 0 idle, 1 in frame, 2 waiting for line high
  int         m_age  = 0;
  int         m_k    = 0;
  logic [7:0] m_byte = 8'd0;
  logic       m_pend = 1'b0;
  logic [7:0] m_pbyte = 8'd0;
  logic [7:0] e_dout = 8'd0;
  logic       e_valid = 1'b0;
  logic       e_ovr = 1'b0;
  logic       e_fe = 1'b0;
  logic       e_busy = 1'b0;

  initial forever begin
    @(posedge sysclk or negedge rst_n);
    if (!rst_n) begin
      m_d1 = 1'b1; m_d2 = 1'b1; m_mode = 0; m_age = 0; m_pend = 1'b0;
      e_dout = 8'd0; e_valid = 1'b0; e_ovr = 1'b0; e_fe = 1'b0; e_busy = 1'b0;
    end else begin
      m_rxs = m_d2;
      m_d2  = m_d1;
      m_d1  = rx;
      if (m_pend) begin
        if (!e_valid || ack) begin
          e_dout  = m_pbyte;
          e_valid = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (ack) begin
        e_valid = 1'b0;
        e_ovr   = 1'b0;
      end
      m_pend = 1'b0;
      e_fe   = 1'b0;
      case (m_mode)
        0: if (!m_rxs) begin m_mode = 1; m_age = 0; end
        1: begin
          m_age = m_age + 1;
          if (m_age == HALF) begin
            if (m_rxs) m_mode = 0;
          end else if (m_age > HALF && ((m_age - HALF) % BIT) == 0) begin
            m_k = (m_age - HALF) / BIT;
            if (m_k <= 8) begin
              m_byte[m_k-1] = m_rxs;
            end else if (m_rxs) begin
              m_pend  = 1'b1;
              m_pbyte = m_byte;
              m_mode  = 0;
            end else begin
              e_fe   = 1'b1;
              m_mode = 2;
            end
          end
        end
        2: if (m_rxs) m_mode = 0;
        default: m_mode = 0;
      endcase
      e_busy = (m_mode != 0);
    end
  end

  // Per-cycle comparison against the model, just after each active edge.
  initial forever begin
    @(posedge sysclk);
    #1;
    chk("dout",      {24'd0, dout},      {24'd0, e_dout});
    chk("valid",     {31'd0, valid},     {31'd0, e_valid});
    chk("overrun",   {31'd0, overrun},   {31'd0, e_ovr});
    chk("frame_err", {31'd0, frame_err}, {31'd0, e_fe});
    chk("busy",      {31'd0, busy},      {31'd0, e_busy});
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stopb, BIT);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge sysclk);
    ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge sysclk);
    chk("rst_dout",  {24'd0, dout}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 10);

    // 1: 0xA5, latency from the first edge that sees rx low is 611 clocks
    fork
      send(8'hA5, 1'b1);
      begin
        lat = 0;
        while (valid !== 1'b1 && lat < 2000) begin
          @(posedge sysclk);
          #1;
          lat = lat + 1;
        end
      end
    join
    chk("t1_latency", lat, 32'd612);
    chk("t1_dout",  {24'd0, dout}, 32'hA5);
    drive(1'b1, 100);
    chk("t1_valid_held", {31'd0, valid}, 32'h1);
    ack_pulse();
    chk("t1_valid_clr", {31'd0, valid}, 32'h0);

    // 2: short glitch is rejected
    fe0 = fe_cnt;
    drive(1'b0, 12);
    chk("t2_busy_on", {31'd0, busy}, 32'h1);
    drive(1'b1, BIT);
    chk("t2_busy_off", {31'd0, busy}, 32'h0);
    chk("t2_valid", {31'd0, valid}, 32'h0);
    chk("t2_fe_cnt", fe_cnt - fe0, 32'd0);

    // 3: bad stop bit followed by a long break, then a good frame
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    drive(1'b0, 39 * BIT);
    chk("t3_fe_cnt", fe_cnt - fe0, 32'd1);
    chk("t3_busy_brk", {31'd0, busy}, 32'h1);
    chk("t3_valid", {31'd0, valid}, 32'h0);
    drive(1'b1, BIT);
    chk("t3_busy_off", {31'd0, busy}, 32'h0);
    send(8'h3C, 1'b1);
    drive(1'b1, BIT);
    chk("t3_dout", {24'd0, dout}, 32'h3C);
    chk("t3_valid2", {31'd0, valid}, 32'h1);
    ack_pulse();

    // 4: overrun
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    drive(1'b1, BIT);
    chk("t4_dout", {24'd0, dout}, 32'h11);
    chk("t4_ovr", {31'd0, overrun}, 32'h1);
    ack_pulse();
    chk("t4_valid_clr", {31'd0, valid}, 32'h0);
    chk("t4_ovr_clr", {31'd0, overrun}, 32'h0);

    // 5: reset in the middle of bit 4 of 0x5A
    fe0 = fe_cnt;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(((8'h5A >> i) & 8'h01) != 8'h00, BIT);
    drive(1'b1, HALF);
    chk("t5_busy_pre", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_dout", {24'd0, dout}, 32'h0);
    chk("t5_rst_busy", {31'd0, busy}, 32'h0);
    chk("t5_rst_valid", {31'd0, valid}, 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    drive(1'b1, 10);
    send(8'h7E, 1'b1);
    drive(1'b1, BIT);
    chk("t5_dout", {24'd0, dout}, 32'h7E);
    chk("t5_valid", {31'd0, valid}, 32'h1);
    chk("t5_ovr", {31'd0, overrun}, 32'h0);
    chk("t5_fe_cnt", fe_cnt - fe0, 32'd0);
    ack_pulse();

    // 6: back-to-back 0x00, 0xFF; ack lands on the 0xFF delivery clock
    p1 = cyc + 1;
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
      end
      begin
        wait (cyc == p1 + 10 * BIT + 610);
        @(negedge sysclk);
        ack = 1'b1;
        @(negedge sysclk);
        ack = 1'b0;
      end
    join
    drive(1'b1, BIT);
    chk("t6_dout", {24'd0, dout}, 32'hFF);
    chk("t6_valid", {31'd0, valid}, 32'h1);
    chk("t6_ovr", {31'd0, overrun}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
